// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI-Lite out-of-order memory slave: response codes,
// throttle LFSR constants and the ready-gating rule.
package axi_slv_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      DECERR = 2'b11
   } resp_e;

   localparam int unsigned LFSR_WIDTH = 16;
   // Taps for x^16 + x^14 + x^13 + x^11 on a left-shifting Fibonacci register.
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic ready_gate(input logic [7:0] slice, input int unsigned pct);
      return ((32'(slice) % 32'd100) < pct);
   endfunction

   function automatic resp_e resp_of(input logic err);
      return err ? DECERR : OKAY;
   endfunction

endpackage

// File: rtl/axi_ooo_mem_slave_if.sv
// AXI-Lite bus bundle between a master and the out-of-order memory slave.
interface axi_ooo_mem_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
);
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [ID_WIDTH-1:0]     arid;
   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [ID_WIDTH-1:0]     rid;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   modport slave (
      input  araddr, arid, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, rready, bready,
      output arready, awready, wready, rdata, rid, rresp, rvalid, bresp, bvalid
   );

   modport master (
      output araddr, arid, arvalid, awaddr, awvalid, wdata, wstrb, wvalid, rready, bready,
      input  arready, awready, wready, rdata, rid, rresp, rvalid, bresp, bvalid
   );
endinterface

// File: rtl/axi_slv_fifo.sv
// Synchronous power-of-two FIFO with full/empty/count flags; push when full and pop when
// empty are ignored.
module axi_slv_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push & ~w_pop) r_count <= r_count + 1'b1;
         else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end
endmodule

// File: rtl/axi_ooo_mem_slave.sv
// AXI-Lite word-memory slave with per-ID read queues and round-robin R launch.
// Define AXI_SLV_BACKPRESSURE_EN to throttle ready/launch with a free-running LFSR.
module axi_ooo_mem_slave
   import axi_slv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned RD_Q_DEPTH = 4,
   parameter int unsigned WR_Q_DEPTH = 4,
   parameter int unsigned READY_PCT  = 75,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input logic                clk,
   input logic                rst,
   axi_ooo_mem_slave_if.slave axi
);
   localparam int unsigned OFF    = $clog2(DATA_WIDTH / 8);
   localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned N_IDS  = 2 ** ID_WIDTH;
   localparam int unsigned RQ_W   = DATA_WIDTH + 2;
   localparam int unsigned WQ_W   = DATA_WIDTH + STRB_W;

   function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
      return |(a >> (OFF + IDX_W));
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic w_gate_ar, w_gate_aw, w_gate_w, w_gate_r, w_gate_b;

`ifdef AXI_SLV_BACKPRESSURE_EN
   logic [LFSR_WIDTH-1:0] r_lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lfsr <= LFSR_SEED;
      else     r_lfsr <= lfsr_step(r_lfsr);
   end

   assign w_gate_ar = ready_gate(r_lfsr[7:0], READY_PCT);
   assign w_gate_aw = ready_gate(r_lfsr[15:8], READY_PCT);
   assign w_gate_w  = ready_gate(r_lfsr[11:4], READY_PCT);
   assign w_gate_r  = ready_gate({r_lfsr[3:0], r_lfsr[15:12]}, READY_PCT);
   assign w_gate_b  = ready_gate(r_lfsr[13:6], READY_PCT);
`else
   assign w_gate_ar = 1'b1;
   assign w_gate_aw = 1'b1;
   assign w_gate_w  = 1'b1;
   assign w_gate_r  = 1'b1;
   assign w_gate_b  = 1'b1;
`endif

   // ---------------- AR: look up memory and queue per ID ----------------
   logic [N_IDS-1:0]      w_rq_full, w_rq_empty, w_rq_push, w_rq_pop;
   logic [RQ_W-1:0]       w_rq_dout [N_IDS];
   logic                  w_ar_fire, w_ar_err;
   logic [DATA_WIDTH-1:0] w_ar_data;
   logic [RQ_W-1:0]       w_rq_din;

   assign axi.arready = ~rst & w_gate_ar & ~w_rq_full[axi.arid];
   assign w_ar_fire   = axi.arvalid & axi.arready;
   assign w_ar_err    = addr_err(axi.araddr);
   // Reads the pre-edge memory, so a same-edge write commit is not visible.
   assign w_ar_data   = w_ar_err ? '0 : r_mem[axi.araddr[OFF +: IDX_W]];
   assign w_rq_din    = {w_ar_data, resp_of(w_ar_err)};

   for (genvar g = 0; g < N_IDS; g++) begin : g_rq
      assign w_rq_push[g] = w_ar_fire & (axi.arid == ID_WIDTH'(g));
      axi_slv_fifo #(.WIDTH(RQ_W), .DEPTH(RD_Q_DEPTH)) u_rq (
         .clk    (clk),
         .rst    (rst),
         .i_push (w_rq_push[g]),
         .i_data (w_rq_din),
         .i_pop  (w_rq_pop[g]),
         .o_data (w_rq_dout[g]),
         .o_full (w_rq_full[g]),
         .o_empty(w_rq_empty[g]),
         .o_count()
      );
   end

   // ---------------- R: round-robin pick starting at r_rr_ptr ----------------
   logic [ID_WIDTH-1:0]   r_rr_ptr, r_rid, w_gnt_id;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_rvalid, w_gnt_found, w_r_launch;

   always_comb begin
      logic [ID_WIDTH-1:0] w_cand;
      w_gnt_found = 1'b0;
      w_gnt_id    = '0;
      w_cand      = '0;
      for (int i = 0; i < N_IDS; i++) begin
         w_cand = r_rr_ptr + ID_WIDTH'(i);
         if (!w_gnt_found && !w_rq_empty[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_id    = w_cand;
         end
      end
   end

   assign w_r_launch = (~r_rvalid | axi.rready) & w_gate_r & w_gnt_found;

   always_comb begin
      w_rq_pop = '0;
      if (w_r_launch) w_rq_pop[w_gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rid    <= '0;
         r_rresp  <= '0;
         r_rr_ptr <= '0;
      end else if (~r_rvalid | axi.rready) begin
         r_rvalid <= w_r_launch;
         if (w_r_launch) begin
            r_rdata  <= w_rq_dout[w_gnt_id][RQ_W-1:2];
            r_rresp  <= w_rq_dout[w_gnt_id][1:0];
            r_rid    <= w_gnt_id;
            r_rr_ptr <= w_gnt_id + 1'b1;
         end
      end
   end

   assign axi.rvalid = r_rvalid;
   assign axi.rdata  = r_rdata;
   assign axi.rid    = r_rid;
   assign axi.rresp  = r_rresp;

   // ---------------- AW / W / B queues and write commit ----------------
   logic                  w_awq_full, w_awq_empty, w_wq_full, w_wq_empty, w_bq_full, w_bq_empty;
   logic [ADDR_WIDTH-1:0] w_awq_dout;
   logic [WQ_W-1:0]       w_wq_dout;
   logic [1:0]            w_bq_dout, w_cm_resp, r_bresp;
   logic                  w_commit, w_cm_err, w_b_launch, r_bvalid;
   logic [IDX_W-1:0]      w_cm_idx;
   logic [STRB_W-1:0]     w_cm_strb;
   logic [DATA_WIDTH-1:0] w_cm_data;

   assign axi.awready = ~rst & w_gate_aw & ~w_awq_full;
   assign axi.wready  = ~rst & w_gate_w & ~w_wq_full;
   assign w_commit    = ~w_awq_empty & ~w_wq_empty & ~w_bq_full;
   assign w_cm_err    = addr_err(w_awq_dout);
   assign w_cm_idx    = w_awq_dout[OFF +: IDX_W];
   assign w_cm_strb   = w_wq_dout[WQ_W-1 -: STRB_W];
   assign w_cm_data   = w_wq_dout[DATA_WIDTH-1:0];
   assign w_cm_resp   = resp_of(w_cm_err);
   assign w_b_launch  = (~r_bvalid | axi.bready) & w_gate_b & ~w_bq_empty;

   axi_slv_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(WR_Q_DEPTH)) u_awq (
      .clk(clk), .rst(rst), .i_push(axi.awvalid & axi.awready), .i_data(axi.awaddr),
      .i_pop(w_commit), .o_data(w_awq_dout), .o_full(w_awq_full), .o_empty(w_awq_empty),
      .o_count()
   );

   axi_slv_fifo #(.WIDTH(WQ_W), .DEPTH(WR_Q_DEPTH)) u_wq (
      .clk(clk), .rst(rst), .i_push(axi.wvalid & axi.wready), .i_data({axi.wstrb, axi.wdata}),
      .i_pop(w_commit), .o_data(w_wq_dout), .o_full(w_wq_full), .o_empty(w_wq_empty),
      .o_count()
   );

   axi_slv_fifo #(.WIDTH(2), .DEPTH(WR_Q_DEPTH)) u_bq (
      .clk(clk), .rst(rst), .i_push(w_commit), .i_data(w_cm_resp),
      .i_pop(w_b_launch), .o_data(w_bq_dout), .o_full(w_bq_full), .o_empty(w_bq_empty),
      .o_count()
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_commit & ~w_cm_err) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_cm_strb[b]) r_mem[w_cm_idx][8*b +: 8] <= w_cm_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bvalid <= 1'b0;
         r_bresp  <= '0;
      end else if (~r_bvalid | axi.bready) begin
         r_bvalid <= w_b_launch;
         if (w_b_launch) r_bresp <= w_bq_dout;
      end
   end

   assign axi.bvalid = r_bvalid;
   assign axi.bresp  = r_bresp;
endmodule

// File: tb/tb_axi_ooo_mem_slave.sv
// Self-checking bench for axi_ooo_mem_slave: vector table plus per-ID R and B scoreboards.
module tb_axi_ooo_mem_slave;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_ooo_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

   axi_ooo_mem_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(256), .RD_Q_DEPTH(4),
      .WR_Q_DEPTH(4), .READY_PCT(75), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .axi(axi)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  id;
      logic [1:0]  resp;
   } vec_t;

   rexp_t      exp_r [16][$];
   logic [1:0] exp_b [$];
   logic [3:0] got_rids [$];
   int         total = 0;
   int         bad = 0;
   logic       s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
   logic [3:0] s_rid;
   logic [31:0] s_rdata;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic int pend();
      int n = exp_b.size();
      for (int i = 0; i < 16; i++) n += exp_r[i].size();
      return n;
   endfunction

   // Sample at the falling edge, then return just after the next rising edge.
   task automatic tick();
      rexp_t e;
      logic [1:0] eb;
      @(negedge clk);
      s_arready = axi.arready;
      s_awready = axi.awready;
      s_wready  = axi.wready;
      s_rvalid  = axi.rvalid;
      s_bvalid  = axi.bvalid;
      s_rid     = axi.rid;
      s_rdata   = axi.rdata;
      if (axi.rvalid && axi.rready) begin
         got_rids.push_back(axi.rid);
         if (exp_r[axi.rid].size() == 0) begin
            total++;
            bad++;
            $display("FAIL r_unexpected: got rid %0d data %h, want no beat", axi.rid, axi.rdata);
         end else begin
            e = exp_r[axi.rid].pop_front();
            check($sformatf("r_data_id%0d", axi.rid), 64'(axi.rdata), 64'(e.data));
            check($sformatf("r_resp_id%0d", axi.rid), 64'(axi.rresp), 64'(e.resp));
         end
      end
      if (axi.bvalid && axi.bready) begin
         if (exp_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected: got bresp %0d, want no beat", axi.bresp);
         end else begin
            eb = exp_b.pop_front();
            check("b_resp", 64'(axi.bresp), 64'(eb));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (pend() != 0 && n < 100) begin
         tick();
         n++;
      end
      check({name, "_drained"}, 64'(pend()), 64'd0);
   endtask

   task automatic issue_ar(input logic [31:0] addr, input logic [3:0] id,
                           input logic [31:0] data, input logic [1:0] resp, input string name);
      int n = 0;
      rexp_t e;
      e.data = data;
      e.resp = resp;
      exp_r[id].push_back(e);
      axi.araddr  = addr;
      axi.arid    = id;
      axi.arvalid = 1'b1;
      do begin
         tick();
         n++;
      end while (!s_arready && n < 50);
      axi.arvalid = 1'b0;
      check({name, "_ar_accept"}, 64'(s_arready), 64'd1);
   endtask

   task automatic issue_wr(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input string name);
      int n = 0;
      bit aw_done = 0;
      bit w_done = 0;
      exp_b.push_back(resp);
      axi.awaddr  = addr;
      axi.wdata   = data;
      axi.wstrb   = strb;
      axi.awvalid = 1'b1;
      axi.wvalid  = 1'b1;
      while (!(aw_done && w_done) && n < 50) begin
         tick();
         n++;
         if (axi.awvalid && s_awready) begin aw_done = 1; axi.awvalid = 1'b0; end
         if (axi.wvalid && s_wready) begin w_done = 1; axi.wvalid = 1'b0; end
      end
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      check({name, "_wr_accept"}, 64'({aw_done, w_done}), 64'd3);
   endtask

   vec_t vecs [12];

   initial begin
      int n;
      logic [11:0] seq;
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4'd0, 2'b00};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0, 4'd3, 2'b00};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 4'd0, 2'b00};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 4'd0, 2'b00};
      vecs[4]  = '{1'b0, 32'h0000_0020, 32'h11BB_33DD, 4'h0, 4'd7, 2'b00};
      vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 4'd2, 2'b11};
      vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 4'd0, 2'b11};
      vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 4'd0, 2'b00};
      vecs[8]  = '{1'b0, 32'h0000_0013, 32'hDEAD_BEEF, 4'h0, 4'd9, 2'b00};
      vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 4'h8, 4'd0, 2'b00};
      vecs[10] = '{1'b0, 32'h0000_03FC, 32'h1200_0000, 4'h0, 4'd15, 2'b00};
      vecs[11] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 4'd6, 2'b11};

      rst = 1'b1;
      axi.araddr = '0; axi.arid = '0; axi.arvalid = 1'b0;
      axi.awaddr = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.rready = 1'b1; axi.bready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_arready", 64'(axi.arready), 64'd0);
      check("rst_awready", 64'(axi.awready), 64'd0);
      check("rst_wready", 64'(axi.wready), 64'd0);
      check("rst_valids", 64'({axi.rvalid, axi.bvalid}), 64'd0);
      check("rst_rfields", 64'({axi.rdata, axi.rid, axi.rresp}), 64'd0);
      check("rst_bresp", 64'(axi.bresp), 64'd0);
      rst = 1'b0;
      tick();
      check("post_rst_arready", 64'(s_arready), 64'd1);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr)
            issue_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp,
                     $sformatf("vec%0d", i));
         else
            issue_ar(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].resp,
                     $sformatf("vec%0d", i));
         drain($sformatf("vec%0d", i));
      end

      // AR accept to rvalid latency.
      issue_ar(32'h10, 4'd3, 32'hDEAD_BEEF, 2'b00, "lat");
      tick();
      check("lat_cycle1_rvalid", 64'(s_rvalid), 64'd0);
      tick();
      check("lat_cycle2_rvalid", 64'(s_rvalid), 64'd1);
      check("lat_cycle2_rid", 64'(s_rid), 64'd3);
      drain("lat");

      // IDs 5,5,2 under R backpressure: round-robin interleaves ID 2 between the ID 5 beats.
      axi.rready = 1'b0;
      got_rids.delete();
      issue_ar(32'h10, 4'd5, 32'hDEAD_BEEF, 2'b00, "rr0");
      issue_ar(32'h20, 4'd5, 32'h11BB_33DD, 2'b00, "rr1");
      issue_ar(32'h400, 4'd2, 32'h0000_0000, 2'b11, "rr2");
      repeat (10) tick();
      check("rr_hold_rvalid", 64'(s_rvalid), 64'd1);
      check("rr_hold_fields", 64'({s_rid, s_rdata}), {28'd0, 4'd5, 32'hDEAD_BEEF});
      axi.rready = 1'b1;
      drain("rr");
      seq = '1;
      if (got_rids.size() == 3) seq = {got_rids[0], got_rids[1], got_rids[2]};
      check("rr_order", 64'(seq), 64'h525);

      // Fill ID 1: one beat parks in the R register, four more fill its queue.
      axi.rready = 1'b0;
      issue_ar(32'h10, 4'd1, 32'hDEAD_BEEF, 2'b00, "q1_0");
      issue_ar(32'h20, 4'd1, 32'h11BB_33DD, 2'b00, "q1_1");
      issue_ar(32'h00, 4'd1, 32'h0000_0000, 2'b00, "q1_2");
      issue_ar(32'h3FC, 4'd1, 32'h1200_0000, 2'b00, "q1_3");
      issue_ar(32'h13, 4'd1, 32'hDEAD_BEEF, 2'b00, "q1_4");
      axi.arid = 4'd1;
      axi.araddr = 32'h0;
      axi.arvalid = 1'b1;
      #1;
      check("q1_full_arready", 64'(axi.arready), 64'd0);
      axi.arvalid = 1'b0;
      issue_ar(32'h20, 4'd0, 32'h11BB_33DD, 2'b00, "q0_other");
      axi.rready = 1'b1;
      drain("q1");

      // Reset in the middle of unmatched AW traffic.
      axi.awaddr = 32'h10;
      axi.awvalid = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         tick();
         if (s_awready) n++;
      end
      check("aw_only_accepts", 64'(n), 64'd4);
      tick();
      check("awq_full_awready", 64'(s_awready), 64'd0);
      rst = 1'b1;
      #1;
      check("midrst_awready", 64'(axi.awready), 64'd0);
      check("midrst_valids", 64'({axi.rvalid, axi.bvalid}), 64'd0);
      axi.awvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("after_rst_awready", 64'(axi.awready), 64'd1);
      axi.wdata = 32'hFFFF_FFFF;
      axi.wstrb = 4'hF;
      axi.wvalid = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!s_wready && n < 50);
      axi.wvalid = 1'b0;
      check("after_rst_w_accept", 64'(s_wready), 64'd1);
      n = 0;
      repeat (10) begin
         tick();
         if (s_bvalid) n++;
      end
      check("after_rst_no_bvalid", 64'(n), 64'd0);
      issue_ar(32'h10, 4'd4, 32'h0000_0000, 2'b00, "mem_cleared");
      drain("mem_cleared");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
